ex_wb_buffer: RTL and testbench

EX_WB_BUFFER -- requirements
Module: ex_wb_buffer

---
 rtl/riscv_wb_pkg.sv | 10 +
 rtl/wb_fwd_lookup.sv | 22 ++
 rtl/ex_wb_buffer.sv | 73 +++++++
 tb/tb_ex_wb_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared write-back definitions: buffer depth and the buffered result entry.
package riscv_wb_pkg;
  localparam int WB_BUF_DEPTH = 2;
  localparam int WB_CNT_W     = $clog2(WB_BUF_DEPTH + 1);

  typedef struct packed {
    logic [5:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_lookup.sv
// Operand lookup against the buffered write-back entries; youngest match wins.
module wb_fwd_lookup
  import riscv_wb_pkg::*;
(
  input  wb_entry_t [WB_BUF_DEPTH-1:0] i_ent,
  input  logic [WB_CNT_W-1:0]          i_cnt,
  input  logic [5:0]                   i_raddr,
  output logic                         o_hit,
  output logic [31:0]                  o_data
);
  // Entry 0 is the oldest, so a later index overrides an earlier match.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < WB_BUF_DEPTH; i++) begin
      if ((i < int'(i_cnt)) && (i_raddr != 6'd0) && (i_ent[i].waddr == i_raddr)) begin
        o_hit  = 1'b1;
        o_data = i_ent[i].wdata;
      end
    end
  end
endmodule

// File: rtl/ex_wb_buffer.sv
// Two-entry in-order buffer between EX results and the shared register-file write port.
module ex_wb_buffer
  import riscv_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_we_i,
  input  logic [5:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        wb_ready_o,
  output logic        rf_we_o,
  output logic [5:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic        rf_gnt_i,
  input  logic        kill_i,
  input  logic [5:0]  fwd_raddr_a_i,
  input  logic [5:0]  fwd_raddr_b_i,
  output logic        fwd_hit_a_o,
  output logic        fwd_hit_b_o,
  output logic [31:0] fwd_data_a_o,
  output logic [31:0] fwd_data_b_o
);
  localparam logic [WB_CNT_W-1:0] FULL = WB_CNT_W'(WB_BUF_DEPTH);

  wb_entry_t [WB_BUF_DEPTH-1:0] r_ent;
  logic [WB_CNT_W-1:0]          r_cnt;
  logic                         w_push, w_pop, w_tail;
  wb_entry_t                    w_new;

  assign wb_ready_o = (r_cnt < FULL);
  assign rf_we_o    = (r_cnt != '0) & ~kill_i;
  assign rf_waddr_o = r_ent[0].waddr;
  assign rf_wdata_o = r_ent[0].wdata;

  assign w_pop  = rf_we_o & rf_gnt_i;
  assign w_push = ex_valid_i & wb_ready_o & ex_we_i & (ex_waddr_i != 6'd0) & ~kill_i;
  assign w_new  = '{waddr: ex_waddr_i, wdata: ex_wdata_i};
  // Tail slot after this cycle's pop has shifted the queue down.
  assign w_tail = (r_cnt == WB_CNT_W'(1)) & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ent <= '0;
    end else if (kill_i) begin
      r_cnt <= '0;
    end else begin
      if (w_pop) r_ent[0] <= r_ent[1];
      if (w_push) begin
        if (w_tail) r_ent[1] <= w_new;
        else        r_ent[0] <= w_new;
      end
      r_cnt <= r_cnt + WB_CNT_W'(w_push) - WB_CNT_W'(w_pop);
    end
  end

  wb_fwd_lookup u_fwd_a (
    .i_ent   (r_ent),
    .i_cnt   (r_cnt),
    .i_raddr (fwd_raddr_a_i),
    .o_hit   (fwd_hit_a_o),
    .o_data  (fwd_data_a_o)
  );

  wb_fwd_lookup u_fwd_b (
    .i_ent   (r_ent),
    .i_cnt   (r_cnt),
    .i_raddr (fwd_raddr_b_i),
    .o_hit   (fwd_hit_b_o),
    .o_data  (fwd_data_b_o)
  );
endmodule

// File: tb/tb_ex_wb_buffer.sv
// Directed bench for ex_wb_buffer with a queue of expected write-backs.
module tb_ex_wb_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_we_i, rf_gnt_i, kill_i;
  logic [5:0]  ex_waddr_i, fwd_raddr_a_i, fwd_raddr_b_i;
  logic [31:0] ex_wdata_i;
  logic        wb_ready_o, rf_we_o, fwd_hit_a_o, fwd_hit_b_o;
  logic [5:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, fwd_data_a_o, fwd_data_b_o;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_wb_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .wb_ready_o(wb_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_gnt_i(rf_gnt_i), .kill_i(kill_i),
    .fwd_raddr_a_i(fwd_raddr_a_i), .fwd_raddr_b_i(fwd_raddr_b_i),
    .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o),
    .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at posedge+1 and let combinational outputs settle.
  task automatic drv(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d,
                     input logic gnt, input logic kill);
    ex_valid_i = v; ex_we_i = we; ex_waddr_i = a; ex_wdata_i = d;
    rf_gnt_i = gnt; kill_i = kill;
    #1;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic expect_push(input logic [5:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic head(input string tag, input bit pop);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = pop ? sb.pop_front() : sb[0];
      chk({tag, "_we"}, 32'(rf_we_o), 32'd1);
      chk({tag, "_addr"}, 32'(rf_waddr_o), 32'(e.a));
      chk({tag, "_data"}, rf_wdata_o, e.d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fwd_raddr_a_i = '0; fwd_raddr_b_i = '0;
    drv(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_ready", 32'(wb_ready_o), 32'd1);
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_addr", 32'(rf_waddr_o), 32'd0);
    chk("rst_data", rf_wdata_o, 32'd0);
    step; step;
    rst_n = 1'b1;
    step;

    // Single push/pop with grant held high.
    drv(1, 1, 6'd5, 32'h0000_1234, 1, 0);
    chk("p1_notvisible", 32'(rf_we_o), 32'd0);
    expect_push(6'd5, 32'h0000_1234);
    step;
    drv(0, 0, 0, 0, 1, 0);
    head("p1_head", 1);
    step;
    chk("p1_empty_we", 32'(rf_we_o), 32'd0);
    chk("p1_empty_rdy", 32'(wb_ready_o), 32'd1);

    // Fill to FULL with no grant, stall a third beat, then drain in order.
    drv(1, 1, 6'd1, 32'hA, 0, 0); expect_push(6'd1, 32'hA); step;
    drv(1, 1, 6'd2, 32'hB, 0, 0); expect_push(6'd2, 32'hB);
    chk("f_rdy_one", 32'(wb_ready_o), 32'd1);
    step;
    drv(1, 1, 6'd3, 32'hC, 0, 0);
    chk("f_rdy_full", 32'(wb_ready_o), 32'd0);
    head("f_hold0", 0);
    step;
    drv(0, 0, 0, 0, 0, 0);
    head("f_hold1", 0);
    drv(0, 0, 0, 0, 1, 0);
    chk("f_no_passthru", 32'(wb_ready_o), 32'd0);
    head("f_pop_x1", 1);
    step;
    chk("f_rdy_after_pop", 32'(wb_ready_o), 32'd1);
    head("f_pop_x2", 1);
    step;
    chk("f_stall_not_stored", 32'(rf_we_o), 32'd0);

    // Forwarding: youngest matching entry wins; address 0 never hits.
    drv(1, 1, 6'd7, 32'h11, 0, 0); expect_push(6'd7, 32'h11); step;
    fwd_raddr_a_i = 6'd7; fwd_raddr_b_i = 6'd0;
    drv(1, 1, 6'd7, 32'h22, 0, 0); expect_push(6'd7, 32'h22);
    chk("fw_one_data", fwd_data_a_o, 32'h11);
    step;
    drv(0, 0, 0, 0, 0, 0);
    chk("fw_hit_a", 32'(fwd_hit_a_o), 32'd1);
    chk("fw_data_a", fwd_data_a_o, 32'h22);
    chk("fw_hit_b0", 32'(fwd_hit_b_o), 32'd0);
    chk("fw_data_b0", fwd_data_b_o, 32'd0);
    fwd_raddr_b_i = 6'd3; #1;
    chk("fw_miss_b", 32'(fwd_hit_b_o), 32'd0);
    drv(0, 0, 0, 0, 1, 0); head("fw_pop11", 1); step;
    chk("fw_after_pop", fwd_data_a_o, 32'h22);
    head("fw_pop22", 1); step;
    chk("fw_empty_hit", 32'(fwd_hit_a_o), 32'd0);
    fwd_raddr_a_i = 6'd0; fwd_raddr_b_i = 6'd0;

    // Dropped beats: waddr 0 and we=0.
    drv(1, 1, 6'd0, 32'hDEAD, 1, 0); step;
    drv(1, 0, 6'd9, 32'hBEEF, 1, 0);
    chk("drop0_we", 32'(rf_we_o), 32'd0);
    chk("drop0_rdy", 32'(wb_ready_o), 32'd1);
    step;
    drv(0, 0, 0, 0, 1, 0);
    chk("drop1_we", 32'(rf_we_o), 32'd0);
    chk("drop1_rdy", 32'(wb_ready_o), 32'd1);

    // Simultaneous push and pop at count 1.
    drv(1, 1, 6'd10, 32'h100, 0, 0); expect_push(6'd10, 32'h100); step;
    drv(1, 1, 6'd11, 32'h101, 1, 0); expect_push(6'd11, 32'h101);
    head("pp_pop10", 1);
    step;
    drv(0, 0, 0, 0, 1, 0);
    chk("pp_rdy", 32'(wb_ready_o), 32'd1);
    head("pp_pop11", 1);
    step;
    chk("pp_empty", 32'(rf_we_o), 32'd0);

    // Kill while FULL with a concurrent beat.
    drv(1, 1, 6'd3, 32'h33, 0, 0); expect_push(6'd3, 32'h33); step;
    drv(1, 1, 6'd4, 32'h44, 0, 0); expect_push(6'd4, 32'h44); step;
    drv(1, 1, 6'd6, 32'h66, 1, 1);
    chk("kill_we", 32'(rf_we_o), 32'd0);
    sb.delete();
    step;
    drv(0, 0, 0, 0, 0, 0);
    chk("kill_empty_we", 32'(rf_we_o), 32'd0);
    chk("kill_rdy", 32'(wb_ready_o), 32'd1);
    drv(1, 1, 6'd8, 32'h88, 0, 0); expect_push(6'd8, 32'h88); step;
    drv(0, 0, 0, 0, 1, 0);
    head("kill_next", 1);
    step;

    // Asynchronous reset with the buffer FULL.
    drv(1, 1, 6'd12, 32'hC1, 0, 0); step;
    drv(1, 1, 6'd13, 32'hC2, 0, 0); step;
    fwd_raddr_a_i = 6'd12; fwd_raddr_b_i = 6'd13;
    drv(0, 0, 0, 0, 0, 0);
    chk("ar_pre_hit", 32'(fwd_hit_b_o), 32'd1);
    chk("ar_pre_rdy", 32'(wb_ready_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rdy", 32'(wb_ready_o), 32'd1);
    chk("ar_we", 32'(rf_we_o), 32'd0);
    chk("ar_addr", 32'(rf_waddr_o), 32'd0);
    chk("ar_data", rf_wdata_o, 32'd0);
    chk("ar_hit_a", 32'(fwd_hit_a_o), 32'd0);
    chk("ar_hit_b", 32'(fwd_hit_b_o), 32'd0);
    chk("ar_data_a", fwd_data_a_o, 32'd0);
    chk("ar_data_b", fwd_data_b_o, 32'd0);
    sb.delete();
    step; step;
    rst_n = 1'b1;
    step;
    drv(1, 1, 6'd9, 32'h99, 1, 0); expect_push(6'd9, 32'h99);
    chk("ar_post_we", 32'(rf_we_o), 32'd0);
    step;
    drv(0, 0, 0, 0, 1, 0);
    head("ar_post_head", 1);
    step;
    chk("ar_post_empty", 32'(rf_we_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
